// File: rtl/opo_package.sv
// Shared widths and types for the OPO control datapath.
package opo_package;

  localparam int unsigned word_width         = 16;
  localparam int unsigned config_reg_width   = 16;
  localparam int unsigned lockin_acc_width   = 2 * word_width + config_reg_width;
  localparam int unsigned lockin_shift_width = 6;
  localparam int unsigned lockin_prod_width  = 2 * word_width;

  // Lock-in demodulator window state
  typedef enum logic [0:0] {
    LOCKIN_IDLE  = 1'b0,
    LOCKIN_ACCUM = 1'b1
  } lockin_state_e;

  // Window tags carried alongside each sample through the pipeline
  typedef struct packed {
    logic                          first;
    logic                          last;
    logic [lockin_shift_width-1:0] shift;
  } lockin_tag_t;

endpackage

// File: rtl/lockin_sat_shift.sv
// Arithmetic right shift of a window sum, then clamp to a signed output word.
module lockin_sat_shift
  import opo_package::*;
(
  input  logic signed [lockin_acc_width-1:0]   sum_i,
  input  logic        [lockin_shift_width-1:0] shift_i,
  output logic signed [word_width-1:0]         res_c_o,
  output logic                                 sat_c_o
);

  localparam logic signed [lockin_acc_width-1:0] sat_max =
    lockin_acc_width'((2 ** (word_width - 1)) - 1);
  localparam logic signed [lockin_acc_width-1:0] sat_min =
    -sat_max - lockin_acc_width'(1);

  logic signed [lockin_acc_width-1:0] shifted_c;

  // Shift then clamp to the representable output range
  always_comb begin
    shifted_c = sum_i >>> shift_i;
    sat_c_o   = 1'b0;
    res_c_o   = shifted_c[word_width-1:0];
    if (shifted_c > sat_max) begin
      res_c_o = sat_max[word_width-1:0];
      sat_c_o = 1'b1;
    end else if (shifted_c < sat_min) begin
      res_c_o = sat_min[word_width-1:0];
      sat_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/lockin_demod.sv
// Dual-phase lock-in demodulator: multiply by sine/cosine references,
// integrate over a programmable window, shift, clamp and publish I/Q.
module lockin_demod
  import opo_package::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic signed [word_width-1:0]         adc_in,
  input  logic signed [word_width-1:0]         sine_ref,
  input  logic signed [word_width-1:0]         cosine_ref,
  input  logic        [config_reg_width-1:0]   integ_len,
  input  logic        [lockin_shift_width-1:0] out_shift,
  output logic signed [word_width-1:0]         i_out,
  output logic signed [word_width-1:0]         q_out,
  output logic                                 valid_out,
  output logic                                 sat_out
);

  lockin_state_e state_q, state_d;
  logic          idle_c;

  logic [config_reg_width-1:0]   cnt_q, cnt_d;
  logic [config_reg_width-1:0]   len_q, len_d;
  logic [lockin_shift_width-1:0] shift_q, shift_d;
  logic [config_reg_width-1:0]   len_eff_c, cur_len_c;
  logic [lockin_shift_width-1:0] cur_shift_c;
  logic                          first_c, last_c;

  logic signed [word_width-1:0] s1_adc_q, s1_sin_q, s1_cos_q;
  logic                         s1_v_q;
  lockin_tag_t                  s1_tag_q;

  logic signed [lockin_prod_width-1:0] prod_i_q, prod_q_q;
  logic                                s2_v_q;
  lockin_tag_t                         s2_tag_q;

  logic signed [lockin_acc_width-1:0] acc_i_q, acc_q_q;
  logic                               s3_last_q;
  logic [lockin_shift_width-1:0]      s3_shift_q;

  logic signed [lockin_acc_width-1:0] fin_i_q, fin_q_q;
  logic                               fin_v_q;
  logic [lockin_shift_width-1:0]      fin_shift_q;

  logic signed [word_width-1:0] res_i_c, res_q_c;
  logic                         sat_i_c, sat_q_c;

  logic signed [word_width-1:0] i_out_q, q_out_q;
  logic                         valid_q, sat_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOCKIN_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: enter ACCUM on enable, fall back to IDLE whenever enable drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCKIN_IDLE:  if (en)  state_d = LOCKIN_ACCUM;
      LOCKIN_ACCUM: if (!en) state_d = LOCKIN_IDLE;
      default:               state_d = LOCKIN_IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    idle_c = 1'b0;
    case (state_q)
      LOCKIN_IDLE: idle_c = 1'b1;
      default:     idle_c = 1'b0;
    endcase
  end

  // Window tagging: length/shift are taken from the inputs on a window's first sample
  always_comb begin
    len_eff_c   = (integ_len == '0) ? config_reg_width'(1) : integ_len;
    first_c     = idle_c || (cnt_q == '0);
    cur_len_c   = first_c ? len_eff_c : len_q;
    cur_shift_c = first_c ? out_shift : shift_q;
    last_c      = (cnt_q == cur_len_c - config_reg_width'(1));
    cnt_d       = '0;
    len_d       = len_q;
    shift_d     = shift_q;
    if (en) begin
      cnt_d   = last_c ? '0 : cnt_q + config_reg_width'(1);
      len_d   = cur_len_c;
      shift_d = cur_shift_c;
    end
  end

  // Sample counter and latched window configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
    end
  end

  // S1: register inputs with their window tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_adc_q <= '0;
      s1_sin_q <= '0;
      s1_cos_q <= '0;
      s1_v_q   <= 1'b0;
      s1_tag_q <= '0;
    end else begin
      s1_adc_q <= adc_in;
      s1_sin_q <= sine_ref;
      s1_cos_q <= cosine_ref;
      s1_v_q   <= en;
      s1_tag_q <= '{first: first_c, last: last_c, shift: cur_shift_c};
    end
  end

  // S2: full-precision signed products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_i_q <= '0;
      prod_q_q <= '0;
      s2_v_q   <= 1'b0;
      s2_tag_q <= '0;
    end else begin
      prod_i_q <= lockin_prod_width'(s1_adc_q) * lockin_prod_width'(s1_sin_q);
      prod_q_q <= lockin_prod_width'(s1_adc_q) * lockin_prod_width'(s1_cos_q);
      s2_v_q   <= s1_v_q && en;
      s2_tag_q <= s1_tag_q;
    end
  end

  // S3: accumulate; a first-tagged product restarts the sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      s3_last_q  <= 1'b0;
      s3_shift_q <= '0;
    end else begin
      if (s2_v_q && en) begin
        if (s2_tag_q.first) begin
          acc_i_q <= lockin_acc_width'(prod_i_q);
          acc_q_q <= lockin_acc_width'(prod_q_q);
        end else begin
          acc_i_q <= acc_i_q + lockin_acc_width'(prod_i_q);
          acc_q_q <= acc_q_q + lockin_acc_width'(prod_q_q);
        end
      end
      s3_last_q  <= s2_v_q && en && s2_tag_q.last;
      s3_shift_q <= s2_tag_q.shift;
    end
  end

  // Capture the completed window sum so the next window can start immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_i_q     <= '0;
      fin_q_q     <= '0;
      fin_v_q     <= 1'b0;
      fin_shift_q <= '0;
    end else begin
      fin_v_q <= s3_last_q && en;
      if (s3_last_q) begin
        fin_i_q     <= acc_i_q;
        fin_q_q     <= acc_q_q;
        fin_shift_q <= s3_shift_q;
      end
    end
  end

  lockin_sat_shift u_sat_i (
    .sum_i   (fin_i_q),
    .shift_i (fin_shift_q),
    .res_c_o (res_i_c),
    .sat_c_o (sat_i_c)
  );

  lockin_sat_shift u_sat_q (
    .sum_i   (fin_q_q),
    .shift_i (fin_shift_q),
    .res_c_o (res_q_c),
    .sat_c_o (sat_q_c)
  );

  // Output registers: update only on a completed window, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_out_q <= '0;
      q_out_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= fin_v_q && en;
      if (fin_v_q && en) begin
        i_out_q <= res_i_c;
        q_out_q <= res_q_c;
        sat_q   <= sat_i_c || sat_q_c;
      end
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign valid_out = valid_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_lockin_demod.sv
// Self-checking bench for lockin_demod: directed vector table, corner
// sequences, and randomized stimulus against a window-sum reference model.
module tb_lockin_demod;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [15:0] adc_in, sine_ref, cosine_ref;
  logic [15:0]        integ_len;
  logic [5:0]         out_shift;
  logic signed [15:0] i_out, q_out;
  logic               valid_out, sat_out;

  lockin_demod dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .adc_in     (adc_in),
    .sine_ref   (sine_ref),
    .cosine_ref (cosine_ref),
    .integ_len  (integ_len),
    .out_shift  (out_shift),
    .i_out      (i_out),
    .q_out      (q_out),
    .valid_out  (valid_out),
    .sat_out    (sat_out)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a window is just a list of samples summed with plain
  // integer arithmetic; completed windows are scheduled 4 edges later.
  typedef struct {
    int  due;
    int  i;
    int  q;
    bit  sat;
  } pend_t;

  pend_t  pending[$];
  int     edge_n;
  int     win_cnt, win_len, win_sh;
  longint sum_i, sum_q;
  int     exp_i, exp_q;
  bit     exp_valid, exp_sat;

  int valid_cnt;
  int prev_valid_edge;
  int last_spacing;
  int first_valid_edge;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic shift_clamp(input longint s, input int sh, output int r, output bit sat);
    longint v;
    v   = s >>> sh;
    sat = 1'b0;
    if (v > 32767) begin
      r = 32767; sat = 1'b1;
    end else if (v < -32768) begin
      r = -32768; sat = 1'b1;
    end else begin
      r = int'(v);
    end
  endtask

  task automatic model_clear();
    pending.delete();
    win_cnt = 0;
    sum_i   = 0;
    sum_q   = 0;
  endtask

  task automatic model_edge(input bit e, input int a, input int s, input int c,
                            input int len, input int sh);
    pend_t p;
    bit    si, sq;
    exp_valid = 1'b0;
    if (!e) begin
      model_clear();
    end else begin
      if (win_cnt == 0) begin
        win_len = (len == 0) ? 1 : len;
        win_sh  = sh;
        sum_i   = 0;
        sum_q   = 0;
      end
      sum_i += longint'(a) * longint'(s);
      sum_q += longint'(a) * longint'(c);
      win_cnt++;
      if (win_cnt == win_len) begin
        p.due = edge_n + 4;
        shift_clamp(sum_i, win_sh, p.i, si);
        shift_clamp(sum_q, win_sh, p.q, sq);
        p.sat = si | sq;
        pending.push_back(p);
        win_cnt = 0;
      end
      if (pending.size() > 0 && pending[0].due == edge_n) begin
        p = pending.pop_front();
        exp_valid = 1'b1;
        exp_i     = p.i;
        exp_q     = p.q;
        exp_sat   = p.sat;
      end
    end
  endtask

  // One clock: drive, let the edge capture, model it, check on the falling edge
  task automatic apply(input bit e, input int a, input int s, input int c,
                       input int len, input int sh);
    en         = e;
    adc_in     = 16'(a);
    sine_ref   = 16'(s);
    cosine_ref = 16'(c);
    integ_len  = 16'(len);
    out_shift  = 6'(sh);
    @(posedge clk);
    edge_n++;
    model_edge(e, a, s, c, len, sh);
    @(negedge clk);
    chk("valid_out", valid_out, exp_valid);
    chk("i_out", i_out, exp_i);
    chk("q_out", q_out, exp_q);
    chk("sat_out", sat_out, exp_sat);
    if (valid_out) begin
      valid_cnt++;
      if (first_valid_edge < 0) first_valid_edge = edge_n;
      if (prev_valid_edge >= 0) last_spacing = edge_n - prev_valid_edge;
      prev_valid_edge = edge_n;
    end
  endtask

  task automatic mark();
    first_valid_edge = -1;
    prev_valid_edge  = -1;
    last_spacing     = -1;
  endtask

  typedef struct {
    int len; int sh; int adc; int sn; int cs;
    int ei;  int eq; bit es;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   e0, cnt0, leff, n, nexp;
    int   a, s, c, len, sh;
    bit   e;
    real  ph;
    longint ai, aq;

    vecs[0] = '{len: 4,  sh: 4, adc: 100,    sn: 200,    cs: -50,   ei: 5000,   eq: -1250,  es: 1'b0};
    vecs[1] = '{len: 4,  sh: 0, adc: 100,    sn: 200,    cs: -50,   ei: 32767,  eq: -20000, es: 1'b1};
    vecs[2] = '{len: 16, sh: 0, adc: -32768, sn: -32768, cs: 32767, ei: 32767,  eq: -32768, es: 1'b1};
    vecs[3] = '{len: 0,  sh: 0, adc: 3,      sn: -7,     cs: 5,     ei: -21,    eq: 15,     es: 1'b0};
    vecs[4] = '{len: 8,  sh: 3, adc: -1000,  sn: 1000,   cs: -1000, ei: -32768, eq: 32767,  es: 1'b1};
    vecs[5] = '{len: 2,  sh: 1, adc: -1,     sn: 1,      cs: 0,     ei: -1,     eq: 0,      es: 1'b0};
    vecs[6] = '{len: 3,  sh: 2, adc: -1,     sn: 1,      cs: 1,     ei: -1,     eq: -1,     es: 1'b0};

    edge_n = 0; valid_cnt = 0;
    exp_i = 0; exp_q = 0; exp_sat = 1'b0; exp_valid = 1'b0;
    model_clear();
    mark();
    rst = 1'b0; en = 1'b0;
    adc_in = '0; sine_ref = '0; cosine_ref = '0; integ_len = '0; out_shift = '0;
    repeat (3) @(negedge clk);
    chk("reset_i_out", i_out, 0);
    chk("reset_q_out", q_out, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_sat", sat_out, 0);
    rst = 1'b1;

    // Directed vector table with constant stimulus
    foreach (vecs[k]) begin
      apply(0, 0, 0, 0, vecs[k].len, vecs[k].sh);
      apply(0, 0, 0, 0, vecs[k].len, vecs[k].sh);
      mark();
      cnt0 = valid_cnt;
      leff = (vecs[k].len == 0) ? 1 : vecs[k].len;
      n    = 3 * leff + 6;
      nexp = (n - 4) / leff;
      for (int t = 0; t < n; t++) begin
        apply(1, vecs[k].adc, vecs[k].sn, vecs[k].cs, vecs[k].len, vecs[k].sh);
        if (valid_out) begin
          chk($sformatf("vec%0d_i", k), i_out, vecs[k].ei);
          chk($sformatf("vec%0d_q", k), q_out, vecs[k].eq);
          chk($sformatf("vec%0d_sat", k), sat_out, vecs[k].es);
          if (last_spacing >= 0) chk($sformatf("vec%0d_spacing", k), last_spacing, leff);
        end
      end
      chk($sformatf("vec%0d_valid_count", k), valid_cnt - cnt0, nexp);
    end

    // Enable dropped two samples into an 8-sample window, then re-raised
    apply(1, 100, 200, -50, 8, 4);
    apply(1, 100, 200, -50, 8, 4);
    cnt0 = valid_cnt;
    repeat (3) apply(0, 100, 200, -50, 8, 4);
    mark();
    e0 = edge_n + 1;
    repeat (8) apply(1, 50, 10, 20, 8, 0);
    chk("partial_no_valid", valid_cnt - cnt0, 0);
    repeat (6) apply(1, 50, 10, 20, 8, 0);
    chk("reraise_first_valid", first_valid_edge - e0, 11);
    chk("reraise_i", i_out, 4000);
    chk("reraise_q", q_out, 8000);

    // Asynchronous reset in the middle of a window
    repeat (2) apply(1, 7, 9, -3, 4, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_i", i_out, 0);
    chk("rst_mid_q", q_out, 0);
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_sat", sat_out, 0);
    model_clear();
    exp_i = 0; exp_q = 0; exp_sat = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mark();
    e0 = edge_n + 1;
    repeat (10) apply(1, 7, 9, -3, 4, 0);
    chk("post_rst_first_valid", first_valid_edge - e0, 7);
    chk("post_rst_i", i_out, 252);

    // Sine-driven refs with adc equal to the quadrature reference
    apply(0, 0, 0, 0, 1024, 24);
    mark();
    cnt0 = valid_cnt;
    for (int t = 0; t < 3 * 1024 + 8; t++) begin
      ph = 2.0 * 3.14159265358979 * real'(t % 64) / 64.0;
      s  = $rtoi(30000.0 * $sin(ph));
      c  = $rtoi(30000.0 * $cos(ph));
      apply(1, c, s, c, 1024, 24);
      if (valid_out) begin
        ai = (i_out < 0) ? -longint'(i_out) : longint'(i_out);
        aq = (q_out < 0) ? -longint'(q_out) : longint'(q_out);
        chk("sine_q_dominates", (aq > 8 * ai + 100) ? 1 : 0, 1);
        if (last_spacing >= 0) chk("sine_spacing", last_spacing, 1024);
      end
    end
    chk("sine_valid_count", valid_cnt - cnt0, 3);

    // Randomized stimulus: enable glitches and mid-window config changes
    len = 5; sh = 8; e = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 19) == 0) len = $urandom_range(0, 12);
      if ($urandom_range(0, 19) == 0) sh  = $urandom_range(0, 40);
      e = ($urandom_range(0, 39) != 0);
      a = int'($urandom_range(0, 65535)) - 32768;
      s = int'($urandom_range(0, 65535)) - 32768;
      c = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0) a = a / 256;
      apply(e, a, s, c, len, sh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
